// File: rtl/seg7_status_pkg.sv
// Purpose: shared mode encoding and hex-to-seven-segment glyph decode.
// Latency: purely combinational helpers.
// Backpressure: none.
package seg7_status_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_EXT  = 2'd1,
        MODE_SCAN = 2'd2,
        MODE_DOWN = 2'd3
    } mode_e;

    // Active-low segments packed as {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_status_driver_key_debounce.sv
// Purpose: synchronise and debounce an active-low push-button, pulse on press.
// Latency: key_press 2 + DEBOUNCE_CYCLES + 1 cycles after a stable key_n change.
// Backpressure: none; glitches shorter than DEBOUNCE_CYCLES are discarded.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic key_press
);
    import seg7_status_pkg::*;

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing samples; accept the new level once the run is long enough.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                press_d = level_q & ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state; everything idles at the released level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_press = press_q;

endmodule

// File: rtl/seg7_status_driver.sv
// Purpose: board status driver - prescaled up/down/ext/scan display value onto HEX digits and LEDs.
// Latency: tick->value 1 cycle, value->hex_n/led 1 cycle, ext_valid->hex_n 2 cycles.
// Backpressure: none; ext_valid is dropped when paused or outside EXT mode.
module seg7_status_driver #(
    parameter int NUM_DIGITS      = 8,
    parameter int LED_W           = 18,
    parameter int TICK_DIV        = 5_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              mode_sel,
    input  logic                    key_n,
    input  logic [4*NUM_DIGITS-1:0] ext_value,
    input  logic                    ext_valid,
    output logic [7*NUM_DIGITS-1:0] hex_n,
    output logic [LED_W-1:0]        led,
    output logic                    tick,
    output logic                    paused
);
    import seg7_status_pkg::*;

    localparam int            VW       = 4 * NUM_DIGITS;
    localparam int            PW       = $clog2(LED_W);
    localparam int            DW       = $clog2(TICK_DIV);
    localparam logic [DW-1:0] PRE_MAX  = DW'(TICK_DIV - 1);
    localparam logic [PW-1:0] POS_MAX  = PW'(LED_W - 1);
    localparam logic [PW-1:0] POS_TURN = PW'(LED_W - 2);

    logic [DW-1:0]           pre_q, pre_d;
    logic                    tick_q, tick_d;
    mode_e                   mode_q, mode_d;
    logic                    paused_q, paused_d;
    logic [VW-1:0]           value_q, value_d;
    logic [PW-1:0]           pos_q, pos_d;
    logic                    dir_q, dir_d;
    logic [LED_W-1:0]        led_q, led_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [VW-1:0]           disp;
    logic [6:0]              seg_d [NUM_DIGITS];
    logic                    key_press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clock     (clock),
        .reset     (reset),
        .key_n     (key_n),
        .key_press (key_press)
    );

    // Free-running prescaler, pause and mode register.
    always_comb begin
        pre_d    = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
        tick_d   = (pre_q == PRE_MAX);
        mode_d   = mode_e'(mode_sel);
        paused_d = paused_q ^ key_press;
    end

    // Value and scan update; pause freezes both, entering SCAN restarts the sweep.
    always_comb begin
        value_d = value_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        if (!paused_q) begin
            case (mode_q)
                MODE_UP:   if (tick_q) value_d = value_q + 1'b1;
                MODE_DOWN: if (tick_q) value_d = value_q - 1'b1;
                MODE_EXT:  if (ext_valid) value_d = ext_value;
                default: begin
                    if (tick_q) begin
                        if (dir_q) begin
                            if (pos_q == POS_MAX) begin
                                dir_d = 1'b0;
                                pos_d = POS_TURN;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b1;
                                pos_d = PW'(1);
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
        if (mode_d == MODE_SCAN && mode_q != MODE_SCAN) begin
            pos_d = '0;
            dir_d = 1'b1;
        end
    end

    // Display source and LED pattern: scan position in SCAN, the value otherwise.
    always_comb begin
        disp  = (mode_q == MODE_SCAN) ? VW'(pos_q) : value_q;
        led_d = (mode_q == MODE_SCAN) ? (LED_W'(1) << pos_q) : LED_W'(value_q);
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign seg_d[i] = hex_to_seg(disp[4*i +: 4]);
    end

    // Pack the per-digit glyphs into the registered segment bus.
    always_comb begin
        hex_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_d[7*i +: 7] = seg_d[i];
        end
    end

    // All state; reset blanks the display and parks the scan at pos 0 going up.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q    <= '0;
            tick_q   <= 1'b0;
            mode_q   <= MODE_UP;
            paused_q <= 1'b0;
            value_q  <= '0;
            pos_q    <= '0;
            dir_q    <= 1'b1;
            led_q    <= '0;
            hex_q    <= '1;
        end else begin
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            mode_q   <= mode_d;
            paused_q <= paused_d;
            value_q  <= value_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            led_q    <= led_d;
            hex_q    <= hex_d;
        end
    end

    assign hex_n  = hex_q;
    assign led    = led_q;
    assign tick   = tick_q;
    assign paused = paused_q;

endmodule

// File: doc/seg7_status_driver.md
# seg7_status_driver

Parametrised board status driver for the DE2-115 HEX and LED banks. It replaces the hard-wired free-running-counter pattern on the board. The block generates a prescaled tick and keeps a display value that can count up, count down, be loaded from an external value, or drive a bouncing LED scan. A debounced push-button toggles pause. It sits in the board top level between the switch and key inputs and the HEX and LED pins.

## Interface
Parameters:
- NUM_DIGITS, 8: number of seven-segment digits; display value width is 4*NUM_DIGITS.
- LED_W, 18: LED bank width; must be at least 2.
- TICK_DIV, 5_000_000: prescaler period in clocks, giving 10 Hz at 50 MHz; must be at least 2.
- DEBOUNCE_CYCLES, 1_000_000: number of consecutive equal samples required to accept a key level change; must be at least 1.

Ports:
- clock, in, 1: single clock domain; all logic is posedge.
- reset, in, 1: asynchronous, active-high. Clears every register immediately; release is synchronous to clock at the board level.
- mode_sel, in, 2: mode select from a switch. 0=COUNT_UP, 1=EXT, 2=SCAN, 3=COUNT_DOWN.
- key_n, in, 1: raw active-low push-button, asynchronous.
- ext_value, in, 4*NUM_DIGITS: external value to display.
- ext_valid, in, 1: one-cycle load strobe for ext_value.
- hex_n, out, 7*NUM_DIGITS: active-low segments. Digit i occupies [7i+6:7i] in the order {g,f,e,d,c,b,a}.
- led, out, LED_W: LED drive, active-high.
- tick, out, 1: one-cycle prescaler pulse.
- paused, out, 1: pause flag.

## Operation
- **Prescaler:** counts 0 to TICK_DIV-1 and wraps to 0. tick is registered high for exactly the cycle after the count reaches TICK_DIV-1. The prescaler runs regardless of mode or pause.
- **Key path:**
  - key_n passes through a 2-flop synchroniser.
  - The debounce counter resets on any mismatch between the synchronised level and the accepted level. When the counter reaches DEBOUNCE_CYCLES, the accepted level is updated.
  - A transition of the accepted level from 1 to 0 produces a one-cycle key_press.
  - The accepted level resets to 1, meaning released.
- **Pause:** each key_press toggles paused.
- **Mode register:** mode_sel is registered each cycle as mode_q. All behaviour below uses mode_q.
- **Effect of paused:** freezes the value counter, ext loads and scan position.
- **COUNT_UP:** value increments by 1 on each tick and wraps from all-ones to 0.
- **COUNT_DOWN:** value decrements by 1 on each tick and wraps from 0 to all-ones.
- **EXT:**
  - value loads ext_value on ext_valid. Ticks are ignored.
  - If paused, ext_valid is dropped, not queued.
  - ext_valid in any non-EXT mode is ignored.
- **SCAN:**
  - pos runs 0..LED_W-1 with a dir bit, 1=up.
  - On each tick: pos steps by one in dir. At pos==LED_W-1 with dir up, dir flips to down and pos becomes LED_W-2. At pos==0 with dir down, dir flips to up and pos becomes 1.
  - Entering SCAN (mode_q changes to 2) forces pos=0 and dir=up in the same cycle, and that cycle's tick is not applied.
  - value is held in SCAN. The digits display pos, zero-extended.
- **Mode changes:** value is retained across all mode changes.
- **led output:**
  - SCAN: one-hot, bit pos.
  - Other modes: the low LED_W bits of value. If 4*NUM_DIGITS < LED_W, value is zero-extended.
- **Digit decode:**
  - Each nibble decodes to standard hex glyphs 0-F. Examples: 0 gives 7'b1000000, 1 gives 7'b1111001, 8 gives 7'b0000000, F gives 7'b0001110.
  - hex_n is registered.

## Timing
- **Reset values:**
  - hex_n: all ones (blank).
  - led: 0; tick: 0; paused: 0.
  - value: 0; pos: 0; dir: up.
  - mode_q: COUNT_UP; prescaler: 0; accepted key: 1.
  - The first clock after reset release shows "0" on every digit.
- **Latency:**
  - tick to value update: 1 cycle.
  - value to hex_n and led: 1 cycle.
  - ext_valid to hex_n: 2 cycles.
  - mode_sel to effect: 1 cycle.
- **Key latency:** a stable key_n change produces key_press 2 + DEBOUNCE_CYCLES + 1 cycles later. paused toggles the cycle after that. Glitches shorter than DEBOUNCE_CYCLES produce no event.
- **Simultaneous tick and key_press:** the tick is still applied, because pause takes effect the following cycle.
- **Simultaneous ext_valid and mode change:** decided by mode_q, the old registered mode.
- **Reset mid-operation:** takes effect asynchronously; all outputs go to their reset values within the same cycle.

## Structure
- **Package seg7_status_pkg:**
  - mode encoding constants: MODE_UP, MODE_EXT, MODE_SCAN, MODE_DOWN.
  - function hex_to_seg, mapping a 4-bit nibble to a 7-bit active-low pattern.
- **Sub-module key_debounce** (parameter DEBOUNCE_CYCLES): contains the synchroniser, debounce counter, accepted level and key_press output.
- **Top level:** prescaler, mode register, value and scan logic, and a generate loop over NUM_DIGITS for decode.

## Test plan
- **Reset and count:** run with TICK_DIV=4 and NUM_DIGITS=2, mode 0, for 20 cycles after reset → hex_n digit0 steps 0,1,2,3,4 on every fourth cycle, and led equals value.
- **Wrap:** mode 0, NUM_DIGITS=2, value at 8'hFF, one tick → value 8'h00. Then mode 3 with one tick → 8'hFF, and hex_n shows "FF" (7'b0001110 on both digits).
- **EXT load:** mode 1, ext_value=32'h1234ABCD with ext_valid for 1 cycle → hex_n shows 1234ABCD 2 cycles later. A load while paused → display unchanged.
- **SCAN bounce:** LED_W=4, mode 2 → led sequence 0001,0010,0100,1000,0100,0010,0001,0010 on successive ticks.
- **Debounce:** DEBOUNCE_CYCLES=8. Apply a 5-cycle key_n low glitch → paused stays 0. Hold key_n low for 20 cycles → paused=1, and the count freezes across 10 ticks. Press again → paused=0.
- **Async reset:** assert reset mid-count with value=8'h3C → hex_n goes to all ones and led to 0 the same cycle without a clock edge, and the count restarts from 0 after release.
